// File: rtl/prim_subreg_pkg.sv
// Shared software access policy types for subregister primitives.
// Used by prim_subreg_arb and prim_subreg_arb_multi.
package prim_subreg_pkg;

    typedef enum logic [2:0] {
        SwAccessRW,
        SwAccessRO,
        SwAccessWO,
        SwAccessW1C,
        SwAccessW1S,
        SwAccessW0C,
        SwAccessRC,
        SwAccessNONE
    } sw_access_e;

    localparam int unsigned MaxNumCh = 32;

    // Every policy except read-only reports a software access on qe.
    function automatic bit sw_has_qe(sw_access_e a);
        return a != SwAccessRO;
    endfunction

    // Only plain write policies can hold a colliding HW update for later.
    function automatic bit sw_can_defer(sw_access_e a);
        return (a == SwAccessRW) || (a == SwAccessWO);
    endfunction

endpackage

// File: rtl/prim_subreg_arb.sv
// Combinational SW/HW merge for a single subregister.
// Produces the write enable and next value for the selected policy.
module prim_subreg_arb
    import prim_subreg_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter sw_access_e  SwAccess = SwAccessRW
) (
    input  logic [DW-1:0] q_i,
    input  logic          we_i,
    input  logic [DW-1:0] wd_i,
    input  logic          de_i,
    input  logic [DW-1:0] d_i,
    output logic          wr_en_o,
    output logic [DW-1:0] wr_data_o
);

    logic [DW-1:0] hw_base;
    logic [DW-1:0] sw_mask;
    logic          unused_in;

    // Some policies ignore SW or q entirely.
    assign unused_in = ^{q_i, we_i, wd_i};

    // Bit operations start from HW data if present, else current value.
    assign hw_base = de_i ? d_i : q_i;
    assign sw_mask = we_i ? wd_i : '0;

    // Per-policy merge of SW and HW contributions.
    always_comb begin
        wr_en_o   = 1'b0;
        wr_data_o = q_i;
        unique case (SwAccess)
            SwAccessRW, SwAccessWO: begin
                wr_en_o   = we_i | de_i;
                wr_data_o = we_i ? wd_i : d_i;
            end
            SwAccessW1S: begin
                wr_en_o   = we_i | de_i;
                wr_data_o = hw_base | sw_mask;
            end
            SwAccessW1C: begin
                wr_en_o   = we_i | de_i;
                wr_data_o = hw_base & ~sw_mask;
            end
            SwAccessW0C: begin
                wr_en_o   = we_i | de_i;
                wr_data_o = we_i ? (hw_base & wd_i) : hw_base;
            end
            SwAccessRC: begin
                wr_en_o   = we_i | de_i;
                wr_data_o = we_i ? '0 : hw_base;
            end
            default: begin
                wr_en_o   = de_i;
                wr_data_o = d_i;
            end
        endcase
    end

endmodule

// File: rtl/prim_subreg_arb_multi.sv
// Multi-channel subregister bank with optional deferred HW updates.
// Deferral logic exists only when PRIM_SUBREG_ARB_DEFER_EN is defined.
module prim_subreg_arb_multi
    import prim_subreg_pkg::*;
#(
    parameter int unsigned   NumCh    = 4,
    parameter int unsigned   DW       = 32,
    parameter sw_access_e    SwAccess = SwAccessRW,
    parameter logic [DW-1:0] ResVal   = '0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [NumCh-1:0]    we_i,
    input  logic [NumCh*DW-1:0] wd_i,
    input  logic [NumCh-1:0]    de_i,
    input  logic [NumCh*DW-1:0] d_i,
    output logic [NumCh*DW-1:0] q_o,
    output logic [NumCh-1:0]    qe_o,
    output logic [NumCh-1:0]    pend_o,
    output logic [NumCh-1:0]    ovf_o,
    input  logic [NumCh-1:0]    ovf_clr_i
);

    localparam bit HasQe = sw_has_qe(SwAccess);

    if (NumCh < 1 || NumCh > MaxNumCh || DW < 1) begin : gen_param_err
        $fatal(1, "prim_subreg_arb_multi: NumCh must be 1..32 and DW >= 1");
    end

    for (genvar c = 0; c < NumCh; c++) begin : gen_ch
        logic [DW-1:0] wd_c;
        logic [DW-1:0] d_c;
        logic [DW-1:0] q_q;
        logic          qe_q;
        logic          wr_en;
        logic [DW-1:0] wr_data;
        logic          apply;
        logic [DW-1:0] slot;
        logic          pend;
        logic          ovf;

        assign wd_c = wd_i[c*DW +: DW];
        assign d_c  = d_i[c*DW +: DW];

        prim_subreg_arb #(
            .DW       (DW),
            .SwAccess (SwAccess)
        ) u_arb (
            .q_i       (q_q),
            .we_i      (we_i[c]),
            .wd_i      (wd_c),
            .de_i      (de_i[c]),
            .d_i       (d_c),
            .wr_en_o   (wr_en),
            .wr_data_o (wr_data)
        );

`ifdef PRIM_SUBREG_ARB_DEFER_EN
        if (sw_can_defer(SwAccess)) begin : gen_defer
            logic          pend_q;
            logic          ovf_q;
            logic [DW-1:0] slot_q;
            logic          collide;

            assign collide = we_i[c] & de_i[c];

            // Held HW data lands only on a cycle with no new writer.
            assign apply = pend_q & ~we_i[c] & ~de_i[c];
            assign slot  = slot_q;
            assign pend  = pend_q;
            assign ovf   = ovf_q;

            // Pending slot, pending flag and sticky overflow.
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    slot_q <= '0;
                    pend_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end else begin
                    if (collide) begin
                        slot_q <= d_c;
                    end
                    pend_q <= collide | (pend_q & we_i[c] & ~de_i[c]);
                    if (collide & pend_q) begin
                        ovf_q <= 1'b1;
                    end else if (ovf_clr_i[c]) begin
                        ovf_q <= 1'b0;
                    end
                end
            end
        end else begin : gen_no_defer
            logic unused_clr;
            assign unused_clr = ovf_clr_i[c];
            assign apply      = 1'b0;
            assign slot       = '0;
            assign pend       = 1'b0;
            assign ovf        = 1'b0;
        end
`else
        logic unused_clr;
        assign unused_clr = ovf_clr_i[c];
        assign apply      = 1'b0;
        assign slot       = '0;
        assign pend       = 1'b0;
        assign ovf        = 1'b0;
`endif

        // Channel value: deferred HW update first, else the merge result.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                q_q <= ResVal;
            end else if (apply) begin
                q_q <= slot;
            end else if (wr_en) begin
                q_q <= wr_data;
            end
        end

        // One-cycle pulse following a sampled SW access.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                qe_q <= 1'b0;
            end else begin
                qe_q <= we_i[c] & HasQe;
            end
        end

        assign q_o[c*DW +: DW] = q_q;
        assign qe_o[c]         = qe_q;
        assign pend_o[c]       = pend;
        assign ovf_o[c]        = ovf;
    end

endmodule
